// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit CPU control path: opcodes, ALU codes,
// FSM state encoding and instruction field positions.
package cpu_defs;
    typedef enum logic [1:0] {
        ST_FETCH     = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_t;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FORWARD = 3'b000;
    localparam logic [2:0] ALU_ADD     = 3'b001;
    localparam logic [2:0] ALU_AND     = 3'b010;
    localparam logic [2:0] ALU_OR      = 3'b011;

    localparam int OPC_LSB  = 24;
    localparam int DST_LSB  = 16;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_LSB = 0;

    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pc_unit.sv
// Program counter: sequential step plus an optional word-scaled signed
// branch offset, applied on the update strobe.
module pc_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        i_update,
    input  logic        i_taken,
    input  logic [7:0]  i_offset,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;
    logic [31:0] w_seq;
    logic [31:0] w_offset;
    logic [31:0] w_next;

    // Targets are relative to the already-incremented PC; wraps mod 2^32.
    assign w_seq    = r_pc + PC_STEP;
    assign w_offset = {{22{i_offset[7]}}, i_offset, 2'b00};
    assign w_next   = i_taken ? (w_seq + w_offset) : w_seq;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pc <= RESET_VALUE;
        end else if (i_update) begin
            r_pc <= w_next;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/cpu_control_unit.sv
// Four-cycle fetch/decode/execute/writeback sequencer: latches the
// instruction, decodes register-file and ALU controls, and steers the PC.
module cpu_control_unit
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_RESET_VALUE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTRUCTION,
    input  logic        ZERO,
    output logic [31:0] PC,
    output logic [2:0]  INADDRESS,
    output logic [2:0]  OUT1ADDRESS,
    output logic [2:0]  OUT2ADDRESS,
    output logic        WRITE,
    output logic [7:0]  IMMEDIATE,
    output logic [2:0]  ALUOP,
    output logic        IMM_SEL,
    output logic        NEG_SEL,
    output logic        ILLEGAL,
    output logic [1:0]  o_dbg_state,
    output logic [31:0] o_dbg_ir
);
    state_t      r_state;
    logic [31:0] r_ir;
    logic        r_zero;
    logic        r_illegal;

    logic [7:0]  w_opcode;
    logic        w_known;
    logic        w_writes;
    logic        w_taken;
    logic        w_update;

    assign w_opcode = r_ir[OPC_LSB +: 8];
    assign w_known  = (w_opcode <= OP_BEQ);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_FETCH;
            r_ir      <= 32'h0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_ir    <= INSTRUCTION;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (!w_known) r_illegal <= 1'b1;
                    r_state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    r_zero  <= ZERO;
                    r_state <= ST_WRITEBACK;
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Unknown opcodes fall through the defaults and behave as a NOP.
    always_comb begin
        ALUOP    = ALU_FORWARD;
        IMM_SEL  = 1'b0;
        NEG_SEL  = 1'b0;
        w_writes = 1'b0;
        w_taken  = 1'b0;
        case (w_opcode)
            OP_LOADI: begin IMM_SEL = 1'b1; w_writes = 1'b1; end
            OP_MOV:   w_writes = 1'b1;
            OP_ADD:   begin ALUOP = ALU_ADD; w_writes = 1'b1; end
            OP_SUB:   begin ALUOP = ALU_ADD; NEG_SEL = 1'b1; w_writes = 1'b1; end
            OP_AND:   begin ALUOP = ALU_AND; w_writes = 1'b1; end
            OP_OR:    begin ALUOP = ALU_OR; w_writes = 1'b1; end
            OP_J:     w_taken = 1'b1;
            OP_BEQ:   begin ALUOP = ALU_ADD; NEG_SEL = 1'b1; w_taken = r_zero; end
            default:  ;
        endcase
    end

    assign INADDRESS   = r_ir[DST_LSB +: 3];
    assign OUT1ADDRESS = r_ir[SRC1_LSB +: 3];
    assign OUT2ADDRESS = r_ir[SRC2_LSB +: 3];
    assign IMMEDIATE   = r_ir[SRC2_LSB +: 8];
    assign w_update    = (r_state == ST_WRITEBACK);
    assign WRITE       = w_update && w_writes;
    assign ILLEGAL     = r_illegal;
    assign o_dbg_state = r_state;
    assign o_dbg_ir    = r_ir;

    pc_unit #(
        .RESET_VALUE (PC_RESET_VALUE)
    ) u_pc_unit (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_update (w_update),
        .i_taken  (w_taken),
        .i_offset (r_ir[DST_LSB +: 8]),
        .o_pc     (PC)
    );
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: drives instruction words one at a
// time and checks decodes, WRITE timing, PC updates and reset behaviour.
module tb_cpu_control_unit;
    logic        CLK;
    logic        RESET;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] PC;
    logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS;
    logic        WRITE;
    logic [7:0]  IMMEDIATE;
    logic [2:0]  ALUOP;
    logic        IMM_SEL, NEG_SEL, ILLEGAL;
    logic [1:0]  dbg_state;
    logic [31:0] dbg_ir;

    logic [31:0] w_pc;
    logic [2:0]  w_inaddr, w_out1, w_out2, w_aluop;
    logic        w_write, w_imm_sel, w_neg_sel, w_illegal;
    logic [7:0]  w_imm;
    logic [1:0]  w_state;
    logic [31:0] w_ir;

    int n_checks = 0;
    int n_errors = 0;

    cpu_control_unit dut (
        .CLK (CLK), .RESET (RESET), .INSTRUCTION (INSTRUCTION), .ZERO (ZERO),
        .PC (PC), .INADDRESS (INADDRESS), .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS), .WRITE (WRITE), .IMMEDIATE (IMMEDIATE),
        .ALUOP (ALUOP), .IMM_SEL (IMM_SEL), .NEG_SEL (NEG_SEL),
        .ILLEGAL (ILLEGAL), .o_dbg_state (dbg_state), .o_dbg_ir (dbg_ir)
    );

    // Second instance starts just below 2^32 and runs "j 0" forever.
    cpu_control_unit #(.PC_RESET_VALUE (32'hFFFF_FFFC)) dut_wrap (
        .CLK (CLK), .RESET (RESET), .INSTRUCTION (32'h0600_0000), .ZERO (1'b0),
        .PC (w_pc), .INADDRESS (w_inaddr), .OUT1ADDRESS (w_out1),
        .OUT2ADDRESS (w_out2), .WRITE (w_write), .IMMEDIATE (w_imm),
        .ALUOP (w_aluop), .IMM_SEL (w_imm_sel), .NEG_SEL (w_neg_sel),
        .ILLEGAL (w_illegal), .o_dbg_state (w_state), .o_dbg_ir (w_ir)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Starts in FETCH; returns in WRITEBACK with ZERO held off-window.
    task automatic to_writeback(input logic [31:0] instr, input logic zero, input logic exp_write,
                                input string tag);
        INSTRUCTION = instr;
        ZERO = ~zero;
        tick();
        check({tag, "_dec_state"}, 32'(dbg_state), 32'd1);
        check({tag, "_dec_write"}, 32'(WRITE), 32'd0);
        INSTRUCTION = 32'hDEAD_BEEF;
        tick();
        check({tag, "_ex_write"}, 32'(WRITE), 32'd0);
        ZERO = zero;
        tick();
        ZERO = ~zero;
        check({tag, "_wb_state"}, 32'(dbg_state), 32'd3);
        check({tag, "_wb_write"}, 32'(WRITE), 32'(exp_write));
    endtask

    task automatic finish_instr(input logic [31:0] exp_pc, input logic exp_ill, input string tag);
        tick();
        check({tag, "_pc"}, PC, exp_pc);
        check({tag, "_fetch_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_fetch_write"}, 32'(WRITE), 32'd0);
        check({tag, "_illegal"}, 32'(ILLEGAL), 32'(exp_ill));
    endtask

    task automatic check_decode(input logic [2:0] ia, input logic [2:0] o1, input logic [2:0] o2,
                                input logic [7:0] imm, input logic [2:0] op, input logic isel,
                                input logic nsel, input string tag);
        check({tag, "_inaddr"}, 32'(INADDRESS), 32'(ia));
        check({tag, "_out1"}, 32'(OUT1ADDRESS), 32'(o1));
        check({tag, "_out2"}, 32'(OUT2ADDRESS), 32'(o2));
        check({tag, "_imm"}, 32'(IMMEDIATE), 32'(imm));
        check({tag, "_aluop"}, 32'(ALUOP), 32'(op));
        check({tag, "_imm_sel"}, 32'(IMM_SEL), 32'(isel));
        check({tag, "_neg_sel"}, 32'(NEG_SEL), 32'(nsel));
    endtask

    initial begin
        RESET = 1'b1;
        INSTRUCTION = 32'h0;
        ZERO = 1'b0;
        #2;
        check("rst_pc", PC, 32'h0);
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_write", 32'(WRITE), 32'd0);
        check("rst_illegal", 32'(ILLEGAL), 32'd0);
        check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
        check_decode(3'd0, 3'd0, 3'd0, 8'h00, 3'b000, 1'b1, 1'b0, "rst");
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        to_writeback(32'h0003_002A, 1'b0, 1'b1, "loadi");
        check_decode(3'd3, 3'd0, 3'd2, 8'h2A, 3'b000, 1'b1, 1'b0, "loadi");
        finish_instr(32'h0000_0004, 1'b0, "loadi");
        check("wrap_pc", w_pc, 32'h0000_0000);

        to_writeback(32'h0305_0102, 1'b0, 1'b1, "sub");
        check_decode(3'd5, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b1, "sub");
        finish_instr(32'h0000_0008, 1'b0, "sub");

        to_writeback(32'h0401_0203, 1'b1, 1'b1, "and");
        check_decode(3'd1, 3'd2, 3'd3, 8'h03, 3'b010, 1'b0, 1'b0, "and");
        finish_instr(32'h0000_000C, 1'b0, "and");

        to_writeback(32'h05FF_F9FA, 1'b0, 1'b1, "or");
        check_decode(3'd7, 3'd1, 3'd2, 8'hFA, 3'b011, 1'b0, 1'b0, "or");
        finish_instr(32'h0000_0010, 1'b0, "or");

        to_writeback(32'h0702_0102, 1'b1, 1'b0, "beq_t");
        check_decode(3'd2, 3'd1, 3'd2, 8'h02, 3'b001, 1'b0, 1'b1, "beq_t");
        finish_instr(32'h0000_001C, 1'b0, "beq_t");

        to_writeback(32'h06FC_0000, 1'b0, 1'b0, "j_back1");
        finish_instr(32'h0000_0010, 1'b0, "j_back1");

        to_writeback(32'h0702_0102, 1'b0, 1'b0, "beq_nt");
        finish_instr(32'h0000_0014, 1'b0, "beq_nt");

        to_writeback(32'h06FE_0000, 1'b0, 1'b0, "j_back2");
        finish_instr(32'h0000_0010, 1'b0, "j_back2");

        to_writeback(32'h06FC_0000, 1'b1, 1'b0, "j_fc");
        finish_instr(32'h0000_0004, 1'b0, "j_fc");

        to_writeback(32'h06FF_0000, 1'b0, 1'b0, "j_self");
        finish_instr(32'h0000_0004, 1'b0, "j_self");

        to_writeback(32'h3F01_0203, 1'b1, 1'b0, "illegal");
        check("illegal_wb_flag", 32'(ILLEGAL), 32'd1);
        finish_instr(32'h0000_0008, 1'b1, "illegal");

        to_writeback(32'h0201_0203, 1'b0, 1'b1, "add_sticky");
        check_decode(3'd1, 3'd2, 3'd3, 8'h03, 3'b001, 1'b0, 1'b0, "add_sticky");
        finish_instr(32'h0000_000C, 1'b1, "add_sticky");

        // Reset mid-EXECUTE of an add.
        INSTRUCTION = 32'h0201_0203;
        tick();
        tick();
        check("rx_pre_state", 32'(dbg_state), 32'd2);
        RESET = 1'b1;
        #1;
        check("rx_pc", PC, 32'h0);
        check("rx_write", 32'(WRITE), 32'd0);
        check("rx_state", 32'(dbg_state), 32'd0);
        check("rx_illegal", 32'(ILLEGAL), 32'd0);
        check("rx_ir", dbg_ir, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Reset while WRITE is high: drops at once, PC not advanced.
        to_writeback(32'h0201_0203, 1'b0, 1'b1, "rw_add");
        RESET = 1'b1;
        #1;
        check("rw_write", 32'(WRITE), 32'd0);
        check("rw_pc", PC, 32'h0);
        check("rw_state", 32'(dbg_state), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        to_writeback(32'h0001_0055, 1'b0, 1'b1, "post_rst");
        finish_instr(32'h0000_0004, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
